program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Writes a program into instruction memory from an 8-bit valid/ready byte stream: the writer end of the
//  word-addressed instruction fetch path.
//  Holds the CPU in reset while loading. Releases it only after all words are written and the checksum matches.
//  Sits between a host byte source (UART/bench) and instruction_memory's write port.
// PARAMETERS
//  DEPTH   64                  instruction memory size in 32-bit words
//  ADDR_W  $clog2(DEPTH)       word-index width (derived, not overridden)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse: begin a load of num_words words
//  num_words    in   16  word count, sampled only on accepted start
//  byte_valid   in   1   source has a byte
//  byte_data    in   8   stream byte
//  byte_ready   out  1   loader accepts byte this cycle (transfer = valid && ready)
//  imem_we      out  1   instruction memory write strobe, 1 cycle per word
//  imem_addr    out  32  byte address of the word being written (word_idx << 2)
//  imem_wdata   out  32  assembled word
//  busy         out  1   load in progress
//  done         out  1   load finished (sticky until next start)
//  error        out  1   checksum mismatch or oversize load (sticky until next start)
//  cpu_hold     out  1   1 = keep CPU in reset; 0 = CPU may run
// BEHAVIOUR
//  Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
//   All counters, the word register and the checksum are 0.
//  FSM states: IDLE, RECV, WRITE, CHECK, FINISH.
//  IDLE:   start -> clear done/error/checksum/counters, cpu_hold=1.
//          num_words > DEPTH -> FINISH with error=1, no bytes accepted.
//          num_words == 0 -> CHECK.
//          otherwise -> RECV.
//  RECV:   byte_ready=1. Each transfer XORs the byte into the checksum and places it little-endian
//          (byte k -> bits 8k+7:8k). The 4th byte -> WRITE.
//  WRITE:  byte_ready=0. imem_we=1 for exactly this cycle; imem_addr=word_idx<<2; imem_wdata=assembled word.
//          Then word_idx++. If word_idx+1 == num_words -> CHECK, else RECV.
//          One word costs >= 5 cycles (4 transfers + 1 write).
//  CHECK:  byte_ready=1. One transfer: the byte must equal the running XOR of all data bytes.
//          Mismatch -> error=1. Either way -> FINISH.
//  FINISH: byte_ready=0, busy=0, done=1. cpu_hold = error (released only on success).
//          A new start restarts the load (same rules as IDLE) and re-asserts cpu_hold the next cycle.
//  busy=1 in RECV/WRITE/CHECK. start is ignored while busy.
//  Stalls: byte_valid low for any number of cycles holds state; a partial word is retained.
//  Reset mid-load: immediate return to reset values; the partial word is discarded; already-written words
//   are not erased.
//  Overflow: word_idx never exceeds num_words-1, so imem_addr never exceeds (DEPTH-1)*4.
//  All arithmetic is unsigned. Checksum is an 8-bit XOR.
// STRUCTURE
//  loader_pkg: loader_state_t enum {IDLE,RECV,WRITE,CHECK,FINISH}; CKSUM_INIT = 8'h00; BYTES_PER_WORD = 4.
//  One sub-module, word_assembler: 2-bit byte counter, 32-bit shift/placement register, word_full flag,
//   clear input.
//  The FSM, word counter and checksum live in program_loader.
// TESTING
//  1. start, num_words=1; bytes b3,03,53,00, checksum e3
//     -> one imem_we, addr 0x0, wdata 0x005303b3; done=1, error=0, cpu_hold=0.
//  2. Same as 1 with checksum 00 -> word still written; done=1, error=1, cpu_hold=1.
//  3. num_words=2, 1-3 idle cycles between bytes; bytes 01..08, checksum 08
//     -> writes 0x04030201@0x0 and 0x08070605@0x4; no byte accepted while byte_ready=0.
//  4. num_words=DEPTH+1 (65) -> byte_ready never 1; done=1, error=1 within 2 cycles; no imem_we.
//  5. reset low after 2 bytes of a 1-word load -> reset values next edge;
//     then rerun scenario 1 -> identical result.
//  6. num_words=0, checksum 00 -> no imem_we; done=1, error=0. A second start while busy is ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream instruction memory loader.
package loader_pkg;

    localparam int unsigned DEPTH_DEF      = 64;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned BYTE_W         = 8;
    localparam logic [BYTE_W-1:0] CKSUM_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        FINISH
    } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four stream bytes little-endian into one 32-bit instruction word.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] word;

    // Word as it will look once the incoming byte lands in its lane
    always_comb begin
        word_c = word;
        word_c[{byte_cnt, 3'b000} +: BYTE_W] = byte_data;
        word_full_c = take && (byte_cnt == IDX_W'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (take) begin
            word     <= word_c;
            byte_cnt <= byte_cnt + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program into instruction memory from a valid/ready byte stream and
// keeps the CPU held in reset until every word is written and the checksum matches.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    loader_state_t     state;
    logic [ADDR_W-1:0] word_idx;
    logic [CNT_W-1:0]  num_words_q;
    logic [BYTE_W-1:0] cksum;

    logic              start_ok_c;
    logic              take_c;
    logic              word_full_c;
    logic [WORD_W-1:0] word_c;

    assign start_ok_c = start && ((state == IDLE) || (state == FINISH));
    assign take_c     = byte_valid && byte_ready && (state == RECV);

    word_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_ok_c),
        .take        (take_c),
        .byte_data   (byte_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Outputs are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            word_idx    <= '0;
            num_words_q <= '0;
            cksum       <= CKSUM_INIT;
            byte_ready  <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_hold    <= 1'b1;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        num_words_q <= num_words;
                        word_idx    <= '0;
                        cksum       <= CKSUM_INIT;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        cpu_hold    <= 1'b1;
                        // An oversize load is rejected before any byte is taken
                        if (num_words > CNT_W'(DEPTH)) begin
                            state      <= FINISH;
                            done       <= 1'b1;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state      <= (num_words == '0) ? CHECK : RECV;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (take_c) begin
                        cksum <= cksum ^ byte_data;
                        if (word_full_c) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= WORD_W'({word_idx, 2'b00});
                            imem_wdata <= word_c;
                        end
                    end
                end
                WRITE: begin
                    byte_ready <= 1'b1;
                    // Index stays at num_words-1 on the last word so the address never wraps
                    if (CNT_W'(word_idx) + CNT_W'(1) == num_words_q) begin
                        state <= CHECK;
                    end else begin
                        state    <= RECV;
                        word_idx <= word_idx + ADDR_W'(1);
                    end
                end
                CHECK: begin
                    if (byte_valid) begin
                        state      <= FINISH;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                        error      <= (byte_data != cksum);
                        cpu_hold   <= (byte_data != cksum);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed scenarios plus randomized loads.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the next expected write
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("imem_addr", imem_addr, e[63:32]);
                    check("imem_wdata", imem_wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_start(input logic [15:0] n);
        start     = 1'b1;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent;
        sent = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 50 && !sent; i++) begin
            if (byte_ready === 1'b1) sent = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (!sent) begin
            n_checks++;
            $display("FAIL send_byte_timeout: byte_ready 0 for 50 cycles, required 1");
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done === 1'b1 && busy === 1'b0) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_done_timeout: done %b busy %b, required done 1 busy 0", done, busy);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  imem_addr,       32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    endtask

    // Reference model: expected writes and verdict come from the byte list alone
    task automatic load(input int n, input logic [7:0] data[$], input logic [7:0] ck,
                        input int gmin, input int gmax, input string tag);
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_err;
        x = 8'h00;
        foreach (data[i]) x = x ^ data[i];
        for (int wi = 0; wi < n; wi++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) w = w | (32'(data[4*wi+k]) << (8*k));
            exp_q.push_back({32'(wi * 4), w});
        end
        exp_err = (ck != x);
        do_start(16'(n));
        foreach (data[i]) send_byte(data[i], int'($urandom_range(gmax, gmin)));
        send_byte(ck, int'($urandom_range(gmax, gmin)));
        wait_done(20);
        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_error"},    32'(error),    32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] x;
        int         n;
        bit         good;

        reset = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
        @(negedge clk);
        check_reset_vals("por");
        tick();
        reset = 1'b1;
        tick();

        // 1: one word, good checksum
        d = '{8'hb3, 8'h03, 8'h53, 8'h00};
        load(1, d, 8'he3, 0, 0, "t1");
        check("t1_wdata_reg", imem_wdata, 32'h005303b3);

        // 2: same word, bad checksum
        load(1, d, 8'h00, 0, 0, "t2");

        // 3: two words with idle gaps
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(2, d, 8'h08, 1, 3, "t3");
        check("t3_last_addr", imem_addr, 32'h4);

        // 4: oversize load rejected
        do_start(16'd65);
        check("t4_ready0", 32'(byte_ready), 32'd0);
        tick();
        check("t4_ready1", 32'(byte_ready), 32'd0);
        check("t4_done",   32'(done),       32'd1);
        check("t4_error",  32'(error),      32'd1);
        check("t4_hold",   32'(cpu_hold),   32'd1);
        check("t4_busy",   32'(busy),       32'd0);

        // 5: reset in the middle of a load, then a clean rerun
        do_start(16'd1);
        send_byte(8'haa, 0);
        send_byte(8'h55, 0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t5");
        tick();
        reset = 1'b1;
        tick();
        d = '{8'hb3, 8'h03, 8'h53, 8'h00};
        load(1, d, 8'he3, 0, 0, "t5b");

        // 6: empty load; a start while busy must not disturb it
        do_start(16'd0);
        check("t6_busy", 32'(busy), 32'd1);
        do_start(16'd65);
        check("t6_busy_after_start", 32'(busy),  32'd1);
        check("t6_error_mid",        32'(error), 32'd0);
        send_byte(8'h00, 0);
        wait_done(10);
        check("t6_done",  32'(done),     32'd1);
        check("t6_error", 32'(error),    32'd0);
        check("t6_hold",  32'(cpu_hold), 32'd0);

        // Randomized loads with stalls and a mix of good and bad checksums
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(5, 1));
            good = 1'($urandom_range(1, 0));
            d = {};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                d.push_back(8'($urandom));
                x = x ^ d[i];
            end
            if (!good) x = x ^ 8'($urandom_range(255, 1));
            load(n, d, x, 0, 2, $sformatf("rnd%0d", r));
        end

        // Full-depth load reaches the last address
        d = {};
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d.push_back(8'($urandom));
            x = x ^ d[i];
        end
        load(64, d, x, 0, 0, "full");
        check("full_last_addr", imem_addr, 32'd252);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
